// File: rtl/sigmoid_if.sv
// Sample stream bundle for the sigmoid block.
//   in_valid / x  : operand sample (Q8.24 signed), driven by the producer
//   out_valid / y : result sample (Q8.24, range [0, 1.0]), driven by the block
// master = producer/consumer side, slave = the sigmoid block itself.
interface sigmoid_if;
  logic        in_valid;
  logic [31:0] x;
  logic        out_valid;
  logic [31:0] y;

  modport master (output in_valid, output x, input out_valid, input y);
  modport slave  (input in_valid, input x, output out_valid, output y);
endinterface

// File: rtl/sigmoid.sv
// Piecewise-linear (PLAN) sigmoid, signed Q8.24 in and out, 2-cycle latency,
// one sample per cycle, no backpressure.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : sigmoid_if.slave (in_valid, x -> out_valid, y)
// Stage 1 registers |x| (saturated), sign and valid; stage 2 registers y.
module sigmoid (
  input  logic       clk,
  input  logic       rst_n,
  sigmoid_if.slave   bus
);

  localparam logic [31:0] ONE   = 32'h0100_0000;  // 1.0
  localparam logic [31:0] HALF  = 32'h0080_0000;  // 0.5
  localparam logic [31:0] C_S2  = 32'h00A0_0000;  // 0.625
  localparam logic [31:0] C_S3  = 32'h00D8_0000;  // 0.84375
  localparam logic [31:0] B_S3  = 32'h0260_0000;  // 2.375
  localparam logic [31:0] B_SAT = 32'h0500_0000;  // 5.0

  // Valid shift register: [0] = stage 1, [1] = stage 2 (out_valid).
  logic [1:0]  vld_q;
  logic [31:0] a_d, a_q;
  logic        sgn_q;
  logic [31:0] f_d;
  logic [31:0] y_d, y_q;

  // |x|; the most negative code has no positive twin, so clamp it.
  always_comb begin
    a_d = bus.x;
    if (bus.x[31]) begin
      if (bus.x == 32'h8000_0000) a_d = 32'h7FFF_FFFF;
      else                        a_d = -bus.x;
    end
  end

  // Segment select with lower-inclusive boundaries; a_q is non-negative so
  // the logical shifts truncate toward zero.
  always_comb begin
    f_d = ONE;
    if (a_q < ONE)        f_d = (a_q >> 2) + HALF;
    else if (a_q < B_S3)  f_d = (a_q >> 3) + C_S2;
    else if (a_q < B_SAT) f_d = (a_q >> 5) + C_S3;
    // f_d <= 1.0 in every segment, so the subtraction cannot underflow.
    y_d = sgn_q ? (ONE - f_d) : f_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      sgn_q <= 1'b0;
      y_q   <= '0;
    end else begin
      vld_q <= {vld_q[0], bus.in_valid};
      if (bus.in_valid) begin
        a_q   <= a_d;
        sgn_q <= bus.x[31];
      end
      if (vld_q[0]) y_q <= y_d;
    end
  end

  assign bus.out_valid = vld_q[1];
  assign bus.y         = y_q;

endmodule

// File: tb/tb_sigmoid.sv
// Scoreboard bench for sigmoid: stimulus pushes {due cycle, expected y};
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_sigmoid;

  logic clk;
  logic rst_n;
  sigmoid_if bus ();

  sigmoid dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] y;
  } exp_t;

  exp_t        q[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [31:0] last_y;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: real-number style segment rules on integers, floor division.
  function automatic logic [31:0] model(input logic [31:0] xv);
    longint s, a, f;
    s = longint'($signed(xv));
    a = (s < 0) ? -s : s;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (a < 16777216)      f = a / 4 + 8388608;
    else if (a < 39845888) f = a / 8 + 10485760;
    else if (a < 83886080) f = a / 32 + 14155776;
    else                   f = 16777216;
    if (s < 0) f = 16777216 - f;
    return f[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset_y", bus.y, 32'd0);
      last_y = '0;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.cyc);
        check("y", bus.y, e.y);
        last_y = e.y;
      end
    end else begin
      check("y_hold", bus.y, last_y);
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        check("missing_out_valid", 32'd0, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic send_exp(input logic [31:0] v, input logic [31:0] e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.x        = v;
    q.push_back('{cyc + 2, e});
  endtask

  task automatic send(input logic [31:0] v);
    send_exp(v, model(v));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.x        = $urandom;  // must not disturb held state
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    last_y = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.x = 32'h1234_5678;
    #1;
    check("por_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("por_y", bus.y, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Segments, symmetry, boundaries against spec constants
    send_exp(32'h0000_0000, 32'h0080_0000);
    send_exp(32'h0080_0000, 32'h00A0_0000);
    send_exp(32'h0200_0000, 32'h00E0_0000);
    send_exp(32'h0400_0000, 32'h00F8_0000);
    send_exp(32'h0600_0000, 32'h0100_0000);
    send_exp(32'hFF00_0000, 32'h0040_0000);
    send_exp(32'hFC00_0000, 32'h0008_0000);
    send_exp(32'h0100_0000, 32'h00C0_0000);
    send_exp(32'h0260_0000, 32'h00EB_0000);
    send_exp(32'h0500_0000, 32'h0100_0000);
    send_exp(32'h8000_0000, 32'h0000_0000);
    send_exp(32'h00FF_FFFF, 32'h00BF_FFFF);  // just below 1.0
    send_exp(32'h025F_FFFF, 32'h00EB_FFFF);  // just below 2.375
    send_exp(32'h04FF_FFFF, 32'h00FF_FFFF);  // just below 5.0
    send_exp(32'h7FFF_FFFF, 32'h0100_0000);
    idle(3);

    // 8 back-to-back random samples
    for (int i = 0; i < 8; i++) send($urandom);
    idle(3);

    // Gap pulses with varied spacing (y must hold between)
    for (int i = 0; i < 6; i++) begin
      send($urandom_range(32'h0700_0000, 0) ^ ((i % 2) ? 32'hF800_0000 : 32'h0));
      idle(i % 3 + 1);
    end
    idle(3);

    // Reset mid-stream: A in stage 1, B on the inputs
    send(32'h0180_0000);
    send(32'hFE00_0000);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    last_y = '0;
    #1;
    check("async_reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("async_reset_y", bus.y, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // First sample right after release, then random traffic with gaps
    send(32'h0300_0000);
    idle(2);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) == 0) idle($urandom_range(2, 1));
      if ($urandom_range(1, 0) == 0) send($urandom);
      else send($urandom_range(32'h0600_0000, 0) | ($urandom_range(1, 0) ? 32'hF800_0000 : 32'h0));
    end
    idle(1);

    begin
      int budget;
      budget = 20;
      while (q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() != 0) begin
        check("drain_timeout", q.size(), 32'd0);
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
